// File: rtl/alu_pkg.sv
// Shared ALU-stage definitions: default widths and the occupancy encoding
// used by two-entry output buffers.
// No logic of its own; imported by the result buffer and its flag helper.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_TAG_W = 4;
  localparam int ALU_CNT_W = 16;

  // Occupancy of a two-entry output/skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_flags.sv
// Zero/negative flag decode of a logic-unit result.
// Latency: purely combinational, zero cycles.
// Backpressure: none, it is a pure function of its input.
module alu_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  output logic             zero,
  output logic             neg
);

  // Flags are taken from the value as it enters the buffer.
  assign zero = (val == '0);
  assign neg  = val[WIDTH-1];

endmodule

// File: rtl/alu_result_buffer.sv
// Registered two-entry output stage for the logic unit, with zero/neg flags and a push counter.
// Latency: push in cycle N is visible on out_* in cycle N+1.
// Backpressure: in_ready drops only when both entries are held; it decodes registered state only.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = ALU_TAG_W,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic [CNT_W-1:0] acc_count
);

  // One buffered result; flags travel with the data so they are never re-derived.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
    logic [WIDTH-1:0] data;
  } entry_t;

  occ_e             state_q, state_d;
  entry_t           head_q, head_d;   // entry 0: drives the outputs
  entry_t           skid_q, skid_d;   // entry 1: absorbs one push while stalled
  logic [CNT_W-1:0] acc_q, acc_d;
  entry_t           new_entry;
  logic             new_zero;
  logic             new_neg;
  logic             push;
  logic             pop;

  alu_flags #(.WIDTH(WIDTH)) u_flags (
    .val  (in_data),
    .zero (new_zero),
    .neg  (new_neg)
  );

  assign new_entry = '{tag: in_tag, zero: new_zero, neg: new_neg, data: in_data};
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // State register: occupancy only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy plus entry movement; a pop from FULL refills the head from skid.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          head_d  = new_entry;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          state_d = ST_FULL;
          skid_d  = new_entry;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs are pure decodes of the registered occupancy.
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
  end

  // Push counter wraps naturally at 2^CNT_W.
  always_comb begin
    acc_d = acc_q;
    if (push) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  // Entry and counter registers; reset clears everything so nothing stale reappears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      acc_q  <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      acc_q  <= acc_d;
    end
  end

  assign out_data  = head_q.data;
  assign out_tag   = head_q.tag;
  assign out_zero  = head_q.zero;
  assign out_neg   = head_q.neg;
  assign acc_count = acc_q;

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage placed directly downstream of the 32-bit bitwise logic unit (AND/OR datapath). It accepts one result per cycle over a valid/ready handshake, computes zero and negative flags, and holds up to two results in a skid buffer so the logic unit never stalls combinationally on the consumer's `out_ready`. It also keeps a wrapping count of accepted results for debug.

## Interface
- `WIDTH`, 32, data width of the logic-unit result
- `TAG_W`, 4, width of the opcode/tag carried alongside each result
- `CNT_W`, 16, width of the accepted-result counter
- `clk` input 1 — single clock, all state updates on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — upstream result present
- `in_ready` output 1 — buffer can accept this cycle
- `in_data` input WIDTH — result from the logic unit
- `in_tag` input TAG_W — opcode/tag of that result
- `out_valid` output 1 — head entry present
- `out_ready` input 1 — consumer accepts head this cycle
- `out_data` output WIDTH — head result
- `out_tag` output TAG_W — head tag
- `out_zero` output 1 — head result == 0
- `out_neg` output 1 — head result bit WIDTH-1
- `acc_count` output CNT_W — number of accepted inputs, modulo 2^CNT_W

## Operation
- Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Flags computed from `in_data` at push and stored with the entry; never recomputed from stored data.
- States (occupancy): EMPTY (0), ONE (1), FULL (2). Entry 0 = output register, entry 1 = skid register.
- EMPTY: push → ONE, entry written to output register.
- ONE: push only → FULL, entry written to skid; pop only → EMPTY; push+pop → ONE, new entry written to output register.
- FULL: push impossible (`in_ready`=0); pop → ONE, skid moved to output register.
- `in_ready` = (state != FULL), decoded from registered state only; no combinational path from `out_ready` or `in_valid` to `in_ready`.
- `out_valid` = (state != EMPTY), registered.
- While `out_valid && !out_ready`, `out_data/out_tag/out_zero/out_neg` held stable.
- Ordering strictly FIFO; no entry dropped or duplicated.
- `acc_count` increments by 1 on every push; 0xFFFF + 1 → 0x0000 (CNT_W=16).
- `in_valid` deasserting without push is legal; no requirement that upstream hold data when `in_ready`=0 beyond standard valid/ready (data must stay stable while `in_valid` && !`in_ready`).

## Timing
- Reset (async, immediate on `rst_n` low): state EMPTY, `out_valid`=0, `out_data`=0, `out_tag`=0, `out_zero`=0, `out_neg`=0, `acc_count`=0; `in_ready`=1 once state is EMPTY.
- Reset mid-operation discards both entries; no output asserted until a new push.
- Latency: push in cycle N → `out_valid` with that entry in cycle N+1.
- Throughput: 1 result/cycle sustained when `out_ready` held high (stays in ONE).
- After `out_ready` drops with continuous input: one more push absorbed (FULL), then `in_ready`=0 from the next cycle.
- All outputs are registers or decode of registered state.

## Structure
- Shared package `alu_pkg`: WIDTH/TAG_W/CNT_W defaults and the EMPTY/ONE/FULL state encoding (2-bit enum), reused by other ALU stages.
- One sub-module: `alu_flags` (combinational zero/neg from a WIDTH-bit value), instantiated once on the input path.

## Test plan
- Reset release, single push `in_data`=0x0000_0000 tag 0x3 with `out_ready`=1 → next cycle `out_valid`=1, `out_zero`=1, `out_neg`=0, `out_tag`=0x3; following cycle `out_valid`=0; `acc_count`=1.
- Stream 0x8000_0001, 0x1234_5678, 0xFFFF_FFFF back-to-back, `out_ready`=1 → outputs in same order one per cycle, neg flags 1,0,1; `in_ready` never drops.
- `out_ready`=0, push 0xA and 0xB → `in_ready`=0 after second push, `out_data`=0xA stable; raise `out_ready` → 0xA then 0xB on consecutive cycles, `in_ready` returns 1 after first pop.
- In ONE, simultaneous push 0xC and pop of 0xA → state stays ONE, `out_data`=0xC next cycle.
- Assert `rst_n`=0 asynchronously (mid-cycle) while FULL → `out_valid`=0, `acc_count`=0 immediately; no stale data after release.
- Preload `acc_count` to 0xFFFE via 0xFFFE pushes, push twice → reads 0xFFFF then 0x0000.
